// File: rtl/memory_bus_router.sv
// memory_bus_router
// Decodes a CPU access against REGIONS base/mask windows and runs it on
// exactly one target port. Each access goes IDLE -> ACCESS -> DONE, with
// optional per-region wait states, a target busy handshake and a timeout
// watchdog. The CPU is held through bus_halt until the DONE cycle.

module memory_bus_router #(
   parameter int                            ADDR_WIDTH     = 24,
   parameter int                            DATA_WIDTH     = 8,
   parameter int                            REGIONS        = 4,
   parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_BASE    = {24'h00C000, 24'h008000, 24'h004000, 24'h000000},
   parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_MASK    = {4{24'hFFC000}},
   parameter logic [REGIONS*4-1:0]          WAIT_STATES    = {4{4'd0}},
   parameter int                            DEFAULT_REGION = 3,
   parameter int                            TIMEOUT        = 1023,
   parameter logic [DATA_WIDTH-1:0]         ERROR_DATA     = 8'hFF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_WIDTH-1:0]         address,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic [DATA_WIDTH-1:0]         data_out,
   input  logic                          bus_enable,
   input  logic                          write_enable,
   output logic                          bus_halt,
   output logic                          bus_error,
   output logic [ADDR_WIDTH-1:0]         target_address,
   output logic [DATA_WIDTH-1:0]         target_data_out,
   output logic [REGIONS-1:0]            target_enable,
   output logic [REGIONS-1:0]            target_write_enable,
   input  logic [REGIONS*DATA_WIDTH-1:0] target_data_in,
   input  logic [REGIONS-1:0]            target_busy
);

   localparam int RW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam bit HAS_DEFAULT = (DEFAULT_REGION >= 0) && (DEFAULT_REGION < REGIONS);
   localparam logic [RW-1:0] DEF_IDX = RW'(HAS_DEFAULT ? DEFAULT_REGION : 0);
   // Busy count on which the watchdog gives up (the TIMEOUT-th busy cycle).
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [RW-1:0]   region;
   logic            lat_we;
   logic            first_cycle;
   logic            err;
   logic [3:0]      wait_cnt;
   logic [TO_W-1:0] timeout_cnt;

   logic            dec_hit;
   logic [RW-1:0]   dec_region;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic            sel_busy;

   assign sel_rdata = target_data_in[region*DATA_WIDTH +: DATA_WIDTH];
   assign sel_busy  = target_busy[region];

   // Address decode: lowest-index matching window wins, else the default region.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      dec_hit    = 1'b0;
      dec_region = '0;
      for (int i = REGIONS - 1; i >= 0; i--) begin
         if ((address & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            dec_hit    = 1'b1;
            dec_region = RW'(i);
         end
      end
      if (!dec_hit && HAS_DEFAULT) begin
         dec_hit    = 1'b1;
         dec_region = DEF_IDX;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and target strobes.
   always_comb begin
      state_next          = state;
      target_enable       = '0;
      target_write_enable = '0;
      case (state)
         IDLE: begin
            if (bus_enable) state_next = dec_hit ? ACCESS : DONE;
         end
         ACCESS: begin
            target_enable[region]       = 1'b1;
            target_write_enable[region] = lat_we & first_cycle;
            if (wait_cnt == 4'd0) begin
               if (!sel_busy)                   state_next = DONE;
               else if (timeout_cnt == TO_LAST) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Access datapath: latches the request, runs the counters, captures read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out        <= '0;
         target_address  <= '0;
         target_data_out <= '0;
         region          <= '0;
         lat_we          <= 1'b0;
         first_cycle     <= 1'b0;
         err             <= 1'b0;
         wait_cnt        <= '0;
         timeout_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus_enable) begin
                  target_address  <= address;
                  target_data_out <= data_in;
                  lat_we          <= write_enable;
                  region          <= dec_region;
                  wait_cnt        <= WAIT_STATES[dec_region*4 +: 4];
                  timeout_cnt     <= '0;
                  first_cycle     <= dec_hit;
                  err             <= !dec_hit;
                  if (!dec_hit && !write_enable) data_out <= ERROR_DATA;
               end
            end
            ACCESS: begin
               first_cycle <= 1'b0;
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else if (sel_busy) begin
                  timeout_cnt <= timeout_cnt + TO_W'(1);
                  if (timeout_cnt == TO_LAST) begin
                     err <= 1'b1;
                     if (!lat_we) data_out <= ERROR_DATA;
                  end
               end else if (!lat_we) begin
                  data_out <= sel_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // CPU-facing status: halt while an access is pending, error flag only in DONE.
   assign bus_halt  = reset & ((state == ACCESS) | ((state == IDLE) & bus_enable));
   assign bus_error = (state == DONE) & err;

endmodule

// File: tb/tb_memory_bus_router.sv
// tb_memory_bus_router
// Scoreboard bench: each access pushes its expected outcome when driven and
// the entry is popped and compared in the DONE cycle. Two instances share
// the inputs: dut1 (3 wait states on region 2, TIMEOUT 8, default region 3)
// and dut2 (no default region).

module tb_memory_bus_router;

   logic        clk;
   logic        reset;
   logic [23:0] address;
   logic [7:0]  data_in;
   logic        bus_enable;
   logic        write_enable;
   logic [3:0]  target_busy;
   logic [7:0]  tdata [4];
   logic [31:0] target_data_in;

   logic [7:0]  dout1, dout2, tdout1, tdout2;
   logic        halt1, halt2, err1, err2;
   logic [23:0] taddr1, taddr2;
   logic [3:0]  en1, en2, we1, we2;

   logic        obs_sel;
   logic [7:0]  obs_dout, obs_tdout;
   logic        obs_halt, obs_err;
   logic [23:0] obs_taddr;
   logic [3:0]  obs_en, obs_we;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0]  data;
      logic        err;
      int          halt;
      logic [3:0]  en;
      int          en_cyc;
      logic [3:0]  we;
      int          we_cyc;
      logic [23:0] addr;
      logic [7:0]  wdata;
   } exp_t;

   exp_t sb[$];

   assign target_data_in = {tdata[3], tdata[2], tdata[1], tdata[0]};

   assign obs_dout  = obs_sel ? dout2  : dout1;
   assign obs_tdout = obs_sel ? tdout2 : tdout1;
   assign obs_halt  = obs_sel ? halt2  : halt1;
   assign obs_err   = obs_sel ? err2   : err1;
   assign obs_taddr = obs_sel ? taddr2 : taddr1;
   assign obs_en    = obs_sel ? en2    : en1;
   assign obs_we    = obs_sel ? we2    : we1;

   memory_bus_router #(
      .WAIT_STATES (16'h0300),
      .TIMEOUT     (8)
   ) dut1 (
      .clk                 (clk),
      .reset               (reset),
      .address             (address),
      .data_in             (data_in),
      .data_out            (dout1),
      .bus_enable          (bus_enable),
      .write_enable        (write_enable),
      .bus_halt            (halt1),
      .bus_error           (err1),
      .target_address      (taddr1),
      .target_data_out     (tdout1),
      .target_enable       (en1),
      .target_write_enable (we1),
      .target_data_in      (target_data_in),
      .target_busy         (target_busy)
   );

   memory_bus_router #(
      .DEFAULT_REGION (4)
   ) dut2 (
      .clk                 (clk),
      .reset               (reset),
      .address             (address),
      .data_in             (data_in),
      .data_out            (dout2),
      .bus_enable          (bus_enable),
      .write_enable        (write_enable),
      .bus_halt            (halt2),
      .bus_error           (err2),
      .target_address      (taddr2),
      .target_data_out     (tdout2),
      .target_enable       (en2),
      .target_write_enable (we2),
      .target_data_in      (target_data_in),
      .target_busy         (target_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic er, input int h,
                               input logic [3:0] en, input int ec,
                               input logic [3:0] we, input int wc);
      exp_t e;
      e.data   = d;
      e.err    = er;
      e.halt   = h;
      e.en     = en;
      e.en_cyc = ec;
      e.we     = we;
      e.we_cyc = wc;
      e.addr   = '0;
      e.wdata  = '0;
      return e;
   endfunction

   // Drives one access, records what the observed instance does each cycle,
   // and compares against the scoreboard entry in the DONE cycle.
   task automatic do_access(input string name, input logic sel, input logic [23:0] addr,
                            input logic [7:0] wd, input logic we, input int r,
                            input int busy_n, input logic [7:0] rdata, input exp_t e);
      exp_t        x;
      int          halt_n = 0;
      int          en_n   = 0;
      int          we_n   = 0;
      logic [3:0]  en_or  = '0;
      logic [3:0]  we_or  = '0;
      logic        done   = 1'b0;
      logic [7:0]  d_dout = '0;
      logic [7:0]  d_tdout = '0;
      logic        d_err  = 1'b0;
      logic [23:0] d_taddr = '0;
      e.addr  = addr;
      e.wdata = wd;
      sb.push_back(e);
      obs_sel = sel;
      @(negedge clk);
      address      = addr;
      data_in      = wd;
      write_enable = we;
      bus_enable   = 1'b1;
      if (busy_n > 0) begin
         target_busy[r] = 1'b1;
         tdata[r]       = 8'h11;
      end else begin
         tdata[r] = rdata;
      end
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (obs_halt) halt_n++;
         if (|obs_en) en_n++;
         if (|obs_we) we_n++;
         en_or |= obs_en;
         we_or |= obs_we;
         if (c > 0 && !obs_halt) begin
            done    = 1'b1;
            d_dout  = obs_dout;
            d_err   = obs_err;
            d_taddr = obs_taddr;
            d_tdout = obs_tdout;
         end else begin
            @(negedge clk);
            // Request withdrawn and inputs scrambled: the latched values must hold.
            bus_enable   = 1'b0;
            address      = ~addr;
            write_enable = ~we;
            data_in      = ~wd;
            if (busy_n > 0 && en_n == busy_n) begin
               target_busy[r] = 1'b0;
               tdata[r]       = rdata;
            end
         end
      end
      x = sb.pop_front();
      check({name, ".done_seen"}, 32'(done), 32'd1);
      check({name, ".halt_cycles"}, halt_n, x.halt);
      check({name, ".enable_mask"}, 32'(en_or), 32'(x.en));
      check({name, ".enable_cycles"}, en_n, x.en_cyc);
      check({name, ".wstrobe_mask"}, 32'(we_or), 32'(x.we));
      check({name, ".wstrobe_cycles"}, we_n, x.we_cyc);
      check({name, ".data_out"}, 32'(d_dout), 32'(x.data));
      check({name, ".bus_error"}, 32'(d_err), 32'(x.err));
      check({name, ".target_address"}, 32'(d_taddr), 32'(x.addr));
      check({name, ".target_data_out"}, 32'(d_tdout), 32'(x.wdata));
      target_busy = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [7:0] m_dout;
      reset        = 1'b0;
      address      = '0;
      data_in      = '0;
      bus_enable   = 1'b1;
      write_enable = 1'b0;
      target_busy  = '0;
      obs_sel      = 1'b0;
      for (int i = 0; i < 4; i++) tdata[i] = 8'h00;

      // Reset state, with bus_enable held high to confirm bus_halt stays low.
      repeat (3) @(negedge clk);
      check("rst.data_out1", 32'(dout1), 32'd0);
      check("rst.bus_halt1", 32'(halt1), 32'd0);
      check("rst.bus_halt2", 32'(halt2), 32'd0);
      check("rst.bus_error1", 32'(err1), 32'd0);
      check("rst.target_enable1", 32'(en1), 32'd0);
      check("rst.target_we1", 32'(we1), 32'd0);
      check("rst.target_address1", 32'(taddr1), 32'd0);
      check("rst.target_data_out1", 32'(tdout1), 32'd0);
      check("rst.data_out2", 32'(dout2), 32'd0);
      bus_enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      m_dout = 8'h00;
      do_access("rd_r1", 1'b0, 24'h004010, 8'hE1, 1'b0, 1, 0, 8'h5A,
                mk(8'h5A, 1'b0, 2, 4'b0010, 1, 4'b0000, 0));
      m_dout = 8'h5A;
      do_access("wr_r0", 1'b0, 24'h000123, 8'h33, 1'b1, 0, 0, 8'h00,
                mk(m_dout, 1'b0, 2, 4'b0001, 1, 4'b0001, 1));
      do_access("rd_default_busy5", 1'b0, 24'h123456, 8'h44, 1'b0, 3, 5, 8'hC3,
                mk(8'hC3, 1'b0, 7, 4'b1000, 6, 4'b0000, 0));
      do_access("rd_r2_wait3", 1'b0, 24'h008004, 8'h55, 1'b0, 2, 0, 8'hA7,
                mk(8'hA7, 1'b0, 5, 4'b0100, 4, 4'b0000, 0));
      do_access("rd_timeout", 1'b0, 24'h000200, 8'h66, 1'b0, 0, 99, 8'h12,
                mk(8'hFF, 1'b1, 9, 4'b0001, 8, 4'b0000, 0));
      do_access("rd_after_timeout", 1'b0, 24'h000010, 8'h77, 1'b0, 0, 0, 8'h96,
                mk(8'h96, 1'b0, 2, 4'b0001, 1, 4'b0000, 0));
      m_dout = 8'h96;
      do_access("wr_r2_wait3", 1'b0, 24'h008100, 8'h5C, 1'b1, 2, 0, 8'h00,
                mk(m_dout, 1'b0, 5, 4'b0100, 4, 4'b0100, 1));
      do_access("wr_timeout", 1'b0, 24'h00C001, 8'hB8, 1'b1, 3, 99, 8'h00,
                mk(m_dout, 1'b1, 9, 4'b1000, 8, 4'b1000, 1));
      do_access("nodef_decode_err", 1'b1, 24'h200000, 8'hD2, 1'b0, 3, 0, 8'hC3,
                mk(8'hFF, 1'b1, 1, 4'b0000, 0, 4'b0000, 0));
      do_access("nodef_rd_r1", 1'b1, 24'h004020, 8'h01, 1'b0, 1, 0, 8'h5A,
                mk(8'h5A, 1'b0, 2, 4'b0010, 1, 4'b0000, 0));

      // Reset pulsed in the middle of a wait-state access on dut1.
      obs_sel = 1'b0;
      @(negedge clk);
      address      = 24'h008004;
      data_in      = 8'h9D;
      write_enable = 1'b0;
      bus_enable   = 1'b1;
      tdata[2]     = 8'h77;
      @(negedge clk);
      check("midrst.pre_enable", 32'(en1), 32'b0100);
      #2;
      reset = 1'b0;
      #1;
      check("midrst.data_out", 32'(dout1), 32'd0);
      check("midrst.bus_halt", 32'(halt1), 32'd0);
      check("midrst.bus_error", 32'(err1), 32'd0);
      check("midrst.target_enable", 32'(en1), 32'd0);
      check("midrst.target_we", 32'(we1), 32'd0);
      check("midrst.target_address", 32'(taddr1), 32'd0);
      check("midrst.target_data_out", 32'(tdout1), 32'd0);
      @(negedge clk);
      bus_enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postrst.idle_enable", 32'(en1), 32'd0);
         check("postrst.idle_error", 32'(err1), 32'd0);
         check("postrst.idle_halt", 32'(halt1), 32'd0);
      end
      do_access("rd_after_reset", 1'b0, 24'h004010, 8'h02, 1'b0, 1, 0, 8'h3C,
                mk(8'h3C, 1'b0, 2, 4'b0010, 1, 4'b0000, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memory_bus_router.md
Name: memory_bus_router

Overview:
- Parametrised successor to the fixed four-bank memory bus.
- Decodes a CPU address against REGIONS base/mask windows and sends each access to exactly one target port.
- Runs a per-access state machine with per-region wait states, a target busy handshake, a timeout watchdog and a bus_error response.
- Sits between the CPU core and the RAM/ROM/peripheral/flash targets. Holds the CPU through bus_halt until the access completes.

Parameters:
- ADDR_WIDTH, 24: CPU and target address width.
- DATA_WIDTH, 8: data width.
- REGIONS, 4: number of target ports.
- REGION_BASE, {24'h00C000,24'h008000,24'h004000,24'h000000}: flattened base per region; region 0 is in the LSBs.
- REGION_MASK, {4{24'hFFC000}}: flattened mask per region. A region matches when (address & mask) == base.
- WAIT_STATES, {4{4'd0}}: flattened 4-bit extra wait cycles per region.
- DEFAULT_REGION, 3: region used when nothing matches. A value >= REGIONS means "no default" and unmatched accesses error.
- TIMEOUT, 1023: maximum busy cycles tolerated before abort.
- ERROR_DATA, 8'hFF: read data returned on an error.

Ports:
- clk  input  1: system clock.
- reset  input  1: asynchronous, active-low reset.
- address  input  ADDR_WIDTH: CPU address.
- data_in  input  DATA_WIDTH: CPU write data.
- data_out  output  DATA_WIDTH: registered read data.
- bus_enable  input  1: CPU access request.
- write_enable  input  1: 1 = write, 0 = read. Sampled together with bus_enable.
- bus_halt  output  1: CPU must stall while this is high.
- bus_error  output  1: high during the DONE cycle of an errored access.
- target_address  output  ADDR_WIDTH: latched access address, shared by all targets.
- target_data_out  output  DATA_WIDTH: latched write data, shared by all targets.
- target_enable  output  REGIONS: one-hot select of the active target.
- target_write_enable  output  REGIONS: one-hot, single-cycle write strobe.
- target_data_in  input  REGIONS*DATA_WIDTH: flattened read data from each target.
- target_busy  input  REGIONS: per-target not-ready flag.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE.
  - data_out = 0, bus_error = 0, target_enable = 0, target_write_enable = 0.
  - target_address = 0, target_data_out = 0, all counters = 0.
  - bus_halt = 0 while reset is asserted.
- Decode:
  - Lowest-index matching region wins.
  - If nothing matches, DEFAULT_REGION is used.
  - If nothing matches and there is no default, the access is a decode error.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On bus_enable = 1: latch address, data_in, write_enable and the decoded region r. Load wait_cnt = WAIT_STATES[r] and timeout_cnt = 0.
  - Next state is ACCESS, or DONE with error on a decode error.
  - No target signals are asserted in IDLE.
- ACCESS:
  - target_enable[r] = 1 for every ACCESS cycle.
  - target_write_enable[r] = 1 only in the first ACCESS cycle, and only for writes.
  - While wait_cnt != 0: decrement wait_cnt.
  - Otherwise, if target_busy[r] = 1: increment timeout_cnt.
    - When timeout_cnt reaches TIMEOUT, go to DONE with error.
  - Otherwise go to DONE. On a read, data_out <= target_data_in[r] is captured on this edge.
- DONE: lasts one cycle.
  - target_enable = 0.
  - bus_error = 1 if the access errored.
  - On an errored read, data_out = ERROR_DATA.
  - On a write, data_out is unchanged.
  - Next state is IDLE.
- bus_halt = (state == ACCESS) | (state == IDLE & bus_enable). It is low in DONE; the CPU consumes data_out in that cycle.
- Latency: minimum access is 3 cycles (IDLE accept, ACCESS, DONE), with bus_halt high for 2 of them. Each wait state or busy cycle adds 1.
- A new access can be accepted in the IDLE cycle right after DONE; there is no back-to-back overlap.
- Error handling:
  - Errored writes never assert target_write_enable on a decode error.
  - A timed-out write has already strobed its write.
- bus_enable falling mid-access does not abort: the access runs to DONE, and target signals are unaffected.
- write_enable and address changes after acceptance are ignored (latched values are used).
- Reset asserted mid-access aborts immediately: all strobes drop and no DONE cycle occurs.
- timeout_cnt is wide enough for TIMEOUT and never wraps. wait_cnt saturates at 0.

Test Plan:
- Read 0x004010, region 1, target_data_in[1] = 8'h5A, no waits: bus_halt high 2 cycles; DONE cycle has data_out = 8'h5A and bus_error = 0; target_enable = 4'b0010 for 1 cycle.
- Write 8'h33 to 0x000123: target_write_enable = 4'b0001 for exactly 1 cycle; target_address = 0x000123; target_data_out = 8'h33; data_out unchanged.
- Address 0x123456 with DEFAULT_REGION = 3, target_busy[3] high for 5 cycles: target_enable = 4'b1000; bus_halt high for 7 cycles; data captured when busy falls.
- WAIT_STATES[2] = 3, read 0x008004: ACCESS lasts 4 cycles; bus_halt high for 5 cycles.
- TIMEOUT = 8, target_busy[0] stuck high on a read: DONE after 8 busy cycles; bus_error = 1; data_out = 8'hFF; next access proceeds normally.
- DEFAULT_REGION = 4, access 0x200000: no target_enable; DONE on the 2nd cycle with bus_error = 1. Separately, reset pulsed low mid-ACCESS: all outputs return to 0 asynchronously and state is IDLE.
